// File: rtl/yz_sweep_ctrl.sv
// ============================================================================
//  Module      : yz_sweep_ctrl
//  Description : On-chip exerciser for the three-input Y/Z gate block.
//                Walks {a,b,c} through 0..7, lets each vector settle for
//                SETTLE_CYCLES, samples Y/Z and scores them against the
//                golden function, then reports a pass/fail verdict.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module yz_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2     // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       y_in,
    input  logic       z_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [2:0] r_vec;
    logic [3:0] r_cnt;
    logic [3:0] r_err_count;
    logic [7:0] r_fail_vec;
    logic       r_pass;

    logic       w_y_exp;
    logic       w_z_exp;
    logic       w_mismatch;

    // Golden function: Z = (a&b&c)|b|c reduces to b|c.
    assign w_y_exp    = r_vec[2] | (r_vec[1] & r_vec[0]);
    assign w_z_exp    = r_vec[1] | r_vec[0];
    assign w_mismatch = (y_in != w_y_exp) || (z_in != w_z_exp);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort only matters while a sweep is running.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)                       w_state_next = S_IDLE;
                else if (r_cnt == c_SETTLE_LAST) w_state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)              w_state_next = S_IDLE;
                else if (r_vec == 3'd7) w_state_next = S_DONE;
                else                    w_state_next = S_SETTLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
        done = (r_state == S_DONE);
    end

    // Datapath: vector, settle counter and scoring registers.
    // pass is loaded on the final sample edge so that it is valid together
    // with err_count/fail_vec in the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec       <= 3'd0;
            r_cnt       <= 4'd0;
            r_err_count <= 4'd0;
            r_fail_vec  <= 8'd0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec       <= 3'd0;
                        r_cnt       <= 4'd0;
                        r_err_count <= 4'd0;
                        r_fail_vec  <= 8'd0;
                        r_pass      <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_vec  <= 3'd0;
                        r_pass <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        r_vec  <= 3'd0;
                        r_pass <= 1'b0;
                    end else begin
                        if (w_mismatch) begin
                            r_err_count       <= r_err_count + 4'd1;
                            r_fail_vec[r_vec] <= 1'b1;
                        end
                        if (r_vec == 3'd7) begin
                            r_pass <= !w_mismatch && (r_err_count == 4'd0);
                        end else begin
                            r_vec <= r_vec + 3'd1;
                            r_cnt <= 4'd0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign a_out     = r_vec[2];
    assign b_out     = r_vec[1];
    assign c_out     = r_vec[0];
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_vec  = r_fail_vec;

endmodule

`default_nettype wire

// File: tb/tb_yz_sweep_ctrl.sv
// ============================================================================
//  Module      : tb_yz_sweep_ctrl
//  Description : Scoreboard bench for yz_sweep_ctrl with a faultable gate
//                model and a vector-level reference of the expected verdict.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_yz_sweep_ctrl;

    localparam int S = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       y_in, z_in;
    logic       a, b, c, busy, done, pass;
    logic [3:0] err;
    logic [7:0] fv;

    // Gate model fault controls
    logic       ystk = 1'b0;
    logic       zstk = 1'b0;
    logic [7:0] fy = 8'h00;
    logic [7:0] fz = 8'h00;

    function automatic logic gy(input logic [2:0] v);
        return v[2] | (v[1] & v[0]);
    endfunction

    function automatic logic gz(input logic [2:0] v);
        return (v[2] & v[1] & v[0]) | v[1] | v[0];
    endfunction

    assign y_in = ystk ? 1'b0 : (gy({a, b, c}) ^ fy[{a, b, c}]);
    assign z_in = zstk ? 1'b0 : (gz({a, b, c}) ^ fz[{a, b, c}]);

    yz_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .y_in(y_in), .z_in(z_in),
        .a_out(a), .b_out(b), .c_out(c),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err), .fail_vec(fv)
    );

    // Two extra instances with correct gate models for settle-time extremes
    logic       st2 = 1'b0;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic       a15, b15, c15, busy15, done15, pass15;
    logic [3:0] err1, err15;
    logic [7:0] fv1, fv15;

    yz_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(st2), .abort(1'b0),
        .y_in(gy({a1, b1, c1})), .z_in(gz({a1, b1, c1})),
        .a_out(a1), .b_out(b1), .c_out(c1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1)
    );

    yz_sweep_ctrl #(.SETTLE_CYCLES(15)) dut15 (
        .clk(clk), .rst(rst), .start(st2), .abort(1'b0),
        .y_in(gy({a15, b15, c15})), .z_in(gz({a15, b15, c15})),
        .a_out(a15), .b_out(b15), .c_out(c15),
        .busy(busy15), .done(done15), .pass(pass15),
        .err_count(err15), .fail_vec(fv15)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endfunction

    typedef struct {
        logic [3:0] e;
        logic [7:0] f;
        logic       p;
        int         at;
    } exp_t;

    exp_t q[$];

    // Verdict expected after the first n vectors have been scored
    function automatic exp_t ref_model(input int n);
        exp_t r;
        r.e = 4'd0; r.f = 8'd0; r.at = 0;
        for (int i = 0; i < n; i++) begin
            logic [2:0] v;
            logic oy, oz;
            v  = 3'(i);
            oy = ystk ? 1'b0 : (gy(v) ^ fy[v]);
            oz = zstk ? 1'b0 : (gz(v) ^ fz[v]);
            if (oy != gy(v) || oz != gz(v)) begin
                r.e = r.e + 4'd1;
                r.f[i] = 1'b1;
            end
        end
        r.p = (r.e == 4'd0);
        return r;
    endfunction

    int sw_start  = 0;
    bit sw_active = 1'b0;

    // Monitor: vector sequencing while a sweep is live, and scoreboard on done
    always @(negedge clk) begin : mon
        int k;
        exp_t x;
        if (!rst) begin
            if (sw_active && cyc >= sw_start) begin
                k = cyc - sw_start;
                if (k < 8 * (S + 1))
                    chk("busy_vec", int'({busy, a, b, c}), int'({1'b1, 3'(k / (S + 1))}));
                else if (k == 8 * (S + 1))
                    chk("busy_end_vec", int'({busy, a, b, c}), int'(4'b0111));
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", int'(done), 0);
                end else begin
                    x = q.pop_front();
                    chk("done_cycle", cyc, x.at);
                    chk("err_count", int'(err), int'(x.e));
                    chk("fail_vec", int'(fv), int'(x.f));
                    chk("pass", int'(pass), int'(x.p));
                end
            end
        end
    end

    int d1_at = -1, d15_at = -1;
    logic p1 = 1'b0, p15 = 1'b0;
    always @(negedge clk) begin
        if (done1 && d1_at < 0)  begin d1_at  = cyc; p1  = pass1;  end
        if (done15 && d15_at < 0) begin d15_at = cyc; p15 = pass15; end
    end

    task automatic do_start();
        exp_t x;
        @(negedge clk);
        start = 1'b1;
        x     = ref_model(8);
        x.at  = cyc + 1 + 8 * (S + 1);
        q.push_back(x);
        sw_start  = cyc + 1;
        sw_active = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        if (i == 400) begin
            tests++; fails++;
            $display("FAIL wait_done: timeout, %0d verdicts outstanding", q.size());
            q.delete();
        end
        sw_active = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag, input logic [3:0] e, input logic [7:0] f);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_vec"},  int'({a, b, c}), 0);
        chk({tag, "_err"},  int'(err), int'(e));
        chk({tag, "_fail"}, int'(fv), int'(f));
        chk({tag, "_pass"}, int'(pass), 0);
    endtask

    // Abort on the first cycle vector k is driven; vectors 0..k-1 are scored
    task automatic abort_at(input int k);
        exp_t x;
        int i;
        do_start();
        for (i = 0; i < 200; i++) begin
            if (int'({a, b, c}) == k) break;
            @(negedge clk);
        end
        if (i == 200) begin
            tests++; fails++;
            $display("FAIL abort_wait: vector %0d never driven", k);
        end
        abort = 1'b1;
        sw_active = 1'b0;
        void'(q.pop_back());
        x = ref_model(k);
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort", x.e, x.f);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_idle("reset", 4'd0, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        // Correct model, then the two stuck-at cases
        do_start(); wait_done();
        zstk = 1'b1;
        do_start(); wait_done();
        chk("zstk_err_const", int'(err), 6);
        zstk = 1'b0; ystk = 1'b1;
        do_start(); wait_done();
        chk("ystk_fail_const", int'(fv), int'(8'b1111_1000));
        ystk = 1'b0;

        // Abort at vector 4 with Z stuck low, then a clean re-sweep
        zstk = 1'b1;
        abort_at(4);
        chk("abort_fail_const", int'(fv), int'(8'b0000_1110));
        zstk = 1'b0;
        do_start(); wait_done();

        // Starts while busy must be ignored
        do_start();
        repeat (5) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done();

        // Randomized fault masks, with occasional random aborts
        for (int n = 0; n < 10; n++) begin
            fy   = 8'($urandom);
            fz   = 8'($urandom);
            ystk = ($urandom_range(0, 7) == 0);
            zstk = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) abort_at($urandom_range(1, 7));
            else begin do_start(); wait_done(); end
        end
        fy = 8'h00; fz = 8'h00; ystk = 1'b0; zstk = 1'b0;

        // Reset mid-sweep: sweep lost, no done
        do_start();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        sw_active = 1'b0;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk_idle("midrst", 4'd0, 8'd0);
        repeat (40) @(negedge clk);
        do_start(); wait_done();

        // Settle-time extremes
        begin
            int e0;
            int i;
            @(negedge clk);
            st2 = 1'b1;
            e0  = cyc + 1;
            @(negedge clk);
            st2 = 1'b0;
            for (i = 0; i < 300; i++) begin
                if (d15_at >= 0) break;
                @(negedge clk);
            end
            chk("settle1_done_cycle", d1_at, e0 + 16);
            chk("settle15_done_cycle", d15_at, e0 + 128);
            chk("settle1_pass", int'(p1), 1);
            chk("settle15_pass", int'(p15), 1);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
